// File: rtl/piano_pkg.sv
// Shared definitions for the piano record/playback blocks: state encoding,
// default widths and the common end address of a take.
package piano_pkg;

    localparam int PIANO_ADDR_W    = 8;
    localparam int PIANO_DATA_W    = 8;
    // Playback reads 0..PIANO_LAST_ADDR, so a full take is PIANO_LAST_ADDR+1 samples.
    localparam int PIANO_LAST_ADDR = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        DONE = 2'd2
    } rec_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Pull-up button front end: optional 2-flop synchronizer followed by a
// falling-edge (press) detector. Build macro: NOTE_RECORDER_SYNC_EN.
module btn_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q,
    output logic [W-1:0] fall
);

    logic [W-1:0] prev;

`ifdef NOTE_RECORDER_SYNC_EN
    logic [W-1:0] sync1, sync2;

    // Two-stage synchronizer; resets to released (all ones) so no false press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= d_in;
            sync2 <= sync1;
        end
    end

    assign q = sync2;
`else
    assign q = d_in;
`endif

    // Previous level for edge detection; released (1) after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '1;
        else        prev <= q;
    end

    assign fall = prev & ~q;

endmodule

// File: rtl/note_recorder.sv
// Write side of the piano memory: records ~btn_in once per tick into RAM
// port B between two record-button presses, or until LAST_ADDR is written.
// Build macro: NOTE_RECORDER_SYNC_EN synchronizes rec_btn and btn_in.
module note_recorder
    import piano_pkg::*;
#(
    parameter int ADDR_W    = PIANO_ADDR_W,
    parameter int DATA_W    = PIANO_DATA_W,
    parameter int LAST_ADDR = PIANO_LAST_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              rec_btn,
    input  logic [DATA_W-1:0] btn_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              recording,
    output logic              rec_done,
    output logic [ADDR_W:0]   rec_len
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(LAST_ADDR);

    rec_state_t        state;
    logic [ADDR_W:0]   wr_cnt;
    logic              rec_s;
    logic              press;
    logic [DATA_W-1:0] btn_s;

    btn_sync_edge #(.W(1)) u_rec_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (rec_btn),
        .q     (rec_s),
        .fall  (press)
    );

`ifdef NOTE_RECORDER_SYNC_EN
    logic [DATA_W-1:0] btn_m;

    // Note buttons synchronized like rec_btn; released (all ones) after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m <= '1;
            btn_s <= '1;
        end else begin
            btn_m <= btn_in;
            btn_s <= btn_m;
        end
    end
`else
    assign btn_s = btn_in;
`endif

    // Record FSM; every output is a register. Press beats a simultaneous tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rec_len   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            recording <= 1'b0;
            rec_done  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        state     <= REC;
                        wr_cnt    <= '0;
                        rec_len   <= '0;
                        recording <= 1'b1;
                    end
                end
                REC: begin
                    if (press) begin
                        state     <= DONE;
                        recording <= 1'b0;
                        rec_done  <= 1'b1;
                    end else if (tick) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_cnt[ADDR_W-1:0];
                        mem_wdata <= ~btn_s;
                        wr_cnt    <= wr_cnt + 1'b1;
                        rec_len   <= rec_len + 1'b1;
                        if (wr_cnt == LAST_CNT) begin
                            state     <= DONE;
                            recording <= 1'b0;
                            rec_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (press) begin
                        state    <= IDLE;
                        rec_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder: full take, early stop, press/tick
// collision, re-arm, asynchronous reset mid-take and a held record button.
module tb_note_recorder;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LAST = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          rec_btn = 1'b1;
    logic [DW-1:0] btn_in = '1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          recording;
    logic          rec_done;
    logic [AW:0]   rec_len;

    int checks = 0;
    int errors = 0;

    // Write log built from the port-B bus.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            wr_total = 0;
    int            wr_beyond = 0;
    logic [AW-1:0] wr_last_addr = '0;

    note_recorder #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LAST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .rec_btn   (rec_btn),
        .btn_in    (btn_in),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .recording (recording),
        .rec_done  (rec_done),
        .rec_len   (rec_len)
    );

    always #5 clk = ~clk;

    // Log each write cycle; a pulse longer than one cycle counts twice.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_total      = wr_total + 1;
            wr_last_addr  = mem_addr;
            if (int'(mem_addr) > LAST) wr_beyond = wr_beyond + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        rec_btn = 1'b0;
        cyc(1);
        rec_btn = 1'b1;
        cyc(4);
    endtask

    task automatic do_tick();
        cyc(3);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        cyc(2);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, recording, rec_done, rec_len} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%0b addr=%0h data=%0h rec=%0b done=%0b len=%0d want all 0",
                     mem_we, mem_addr, mem_wdata, recording, rec_done, rec_len);
        end
        rst_n = 1'b1;
        cyc(2);
        do_tick();
        checks++;
        if (wr_total !== 0 || recording !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick got writes=%0d rec=%0b want 0 0", wr_total, recording);
        end
    endtask

    task automatic test_full_take();
        int base = wr_total;
        int bad = 0;
        press();
        checks++;
        if (recording !== 1'b1 || rec_len !== '0) begin
            errors++;
            $display("FAIL full_start got rec=%0b len=%0d want 1 0", recording, rec_len);
        end
        btn_in = 8'hFE;
        for (int i = 0; i <= LAST; i++) begin
            if (i == 5) btn_in = 8'hFD;
            do_tick();
        end
        do_tick();
        for (int a = 0; a <= LAST; a++)
            if (mem[a] !== ((a < 5) ? 8'h01 : 8'h02)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_data got %0d wrong addresses want 0", bad);
        end
        checks++;
        if (wr_total - base != LAST + 1 || wr_beyond != 0 || wr_last_addr !== 8'(LAST)) begin
            errors++;
            $display("FAIL full_count got writes=%0d beyond=%0d last=%0d want 17 0 16",
                     wr_total - base, wr_beyond, wr_last_addr);
        end
        checks++;
        if (rec_len !== 9'd17 || rec_done !== 1'b1 || recording !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL full_done got len=%0d done=%0b rec=%0b we=%0b want 17 1 0 0",
                     rec_len, rec_done, recording, mem_we);
        end
        btn_in = '1;
        press();
    endtask

    task automatic test_early_stop();
        int base = wr_total;
        press();
        repeat (3) do_tick();
        press();
        checks++;
        if (wr_total - base != 3 || wr_last_addr !== 8'd2) begin
            errors++;
            $display("FAIL early_writes got %0d last=%0d want 3 2", wr_total - base, wr_last_addr);
        end
        checks++;
        if (rec_len !== 9'd3 || rec_done !== 1'b1 || recording !== 1'b0) begin
            errors++;
            $display("FAIL early_state got len=%0d done=%0b rec=%0b want 3 1 0",
                     rec_len, rec_done, recording);
        end
    endtask

    task automatic test_rearm();
        int base = wr_total;
        press();
        checks++;
        if (rec_done !== 1'b0 || recording !== 1'b0) begin
            errors++;
            $display("FAIL rearm_idle got done=%0b rec=%0b want 0 0", rec_done, recording);
        end
        press();
        checks++;
        if (recording !== 1'b1 || rec_len !== '0) begin
            errors++;
            $display("FAIL rearm_rec got rec=%0b len=%0d want 1 0", recording, rec_len);
        end
        btn_in = 8'h5A;
        do_tick();
        checks++;
        if (wr_total - base != 1 || wr_last_addr !== 8'd0 || mem[0] !== 8'hA5 || rec_len !== 9'd1) begin
            errors++;
            $display("FAIL rearm_write got n=%0d addr=%0d data=%0h len=%0d want 1 0 a5 1",
                     wr_total - base, wr_last_addr, mem[0], rec_len);
        end
        btn_in = '1;
        press();
        press();
    endtask

    task automatic test_simultaneous();
        int base = wr_total;
        press();
        repeat (2) do_tick();
        cyc(3);
        tick = 1'b1;
        rec_btn = 1'b0;
        cyc(1);
        tick = 1'b0;
        rec_btn = 1'b1;
        cyc(4);
        checks++;
        if (wr_total - base != 2 || rec_len !== 9'd2 || rec_done !== 1'b1) begin
            errors++;
            $display("FAIL simul got writes=%0d len=%0d done=%0b want 2 2 1",
                     wr_total - base, rec_len, rec_done);
        end
        press();
    endtask

    task automatic test_reset_mid_take();
        int base;
        press();
        repeat (4) do_tick();
        base = wr_total;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, recording, rec_done, rec_len} !== '0) begin
            errors++;
            $display("FAIL async_reset got addr=%0h data=%0h rec=%0b len=%0d want all 0",
                     mem_addr, mem_wdata, recording, rec_len);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        repeat (3) do_tick();
        checks++;
        if (wr_total != base || recording !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got writes=%0d rec=%0b want %0d 0", wr_total, recording, base);
        end
        press();
        checks++;
        if (recording !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_press got rec=%0b want 1", recording);
        end
        press();
        press();
    endtask

    task automatic test_held_button();
        rec_btn = 1'b0;
        cyc(50);
        rec_btn = 1'b1;
        cyc(4);
        checks++;
        if (recording !== 1'b1 || rec_done !== 1'b0) begin
            errors++;
            $display("FAIL held_btn got rec=%0b done=%0b want 1 0", recording, rec_done);
        end
        press();
        press();
    endtask

    initial begin
        test_reset();
        test_full_take();
        test_early_stop();
        test_rearm();
        test_simultaneous();
        test_reset_mid_take();
        test_held_button();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
